count_job_arbiter: RTL and testbench

Shared-counter scheduler for the 4-bit up/down counter datapath. It accepts counting jobs from NREQ requesters, each job being a start value, a direction and a step count. Jobs are granted round-robin and run one at a time on a single internal wrap-around counter. The owner receives a one-cycle completion pulse. It sits between client blocks that need timed count sequences and the counter resource, so multiple clients can use one counter without conflicts.

---
 rtl/count_job_arbiter.sv | 166 ++++++++++++++++
 tb/tb_count_job_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/count_job_arbiter.sv
// count_job_arbiter
// Shares one wrap-around up/down counter between NREQ requesters. Each job
// (start value, direction, step count) is granted round-robin, runs to
// completion on the shared counter, and ends with a one-cycle done pulse to
// the job's owner.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   req_valid  [NREQ]        requester i has a job pending
//   req_dir    [NREQ]        requester i direction (1 = up, 0 = down)
//   req_start  [NREQ*WIDTH]  requester i start value at [i*WIDTH +: WIDTH]
//   req_len    [NREQ*WIDTH]  requester i step count at [i*WIDTH +: WIDTH]
//   hold       freezes a running job while high
//   req_ready  [NREQ]        one-hot accept strobe (combinational, IDLE only)
//   count      [WIDTH]       counter value (registered)
//   owner      [NREQ]        one-hot owner of current/last job (registered)
//   busy       high whenever not IDLE
//   done       [NREQ]        one-hot completion pulse to the owner
module count_job_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*WIDTH-1:0] req_start,
    input  logic [NREQ*WIDTH-1:0] req_len,
    input  logic                  hold,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       owner,
    output logic                  busy,
    output logic [NREQ-1:0]       done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] remaining_reg, remaining_next;
    logic             dir_reg, dir_next;
    logic [NREQ-1:0]  owner_reg, owner_next;
    logic [PW-1:0]    ptr_reg, ptr_next;

    // Per-requester payload views.
    logic [WIDTH-1:0] start_arr [NREQ];
    logic [WIDTH-1:0] len_arr   [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign start_arr[gi] = req_start[gi*WIDTH +: WIDTH];
            assign len_arr[gi]   = req_len[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting at the pointer. The first valid requester
    // in rotated order wins; the one-hot mask avoids variable bit-selects.
    logic             grant_found;
    logic [NREQ-1:0]  grant_oh;
    logic [PW-1:0]    grant_ptr_next;
    logic [WIDTH-1:0] grant_start;
    logic [WIDTH-1:0] grant_len;
    logic             grant_dir;

    always_comb begin
        int idx_int;
        logic [NREQ-1:0] sel;
        grant_found    = 1'b0;
        grant_oh       = '0;
        grant_ptr_next = '0;
        idx_int        = 0;
        sel            = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_int = (int'(ptr_reg) + k) % NREQ;
            sel     = NREQ'(1) << idx_int;
            if (!grant_found && ((req_valid & sel) != '0)) begin
                grant_found    = 1'b1;
                grant_oh       = sel;
                grant_ptr_next = PW'((idx_int + 1) % NREQ);
            end
        end
    end

    // Payload mux driven by the one-hot grant.
    always_comb begin
        grant_start = '0;
        grant_len   = '0;
        grant_dir   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                grant_start = start_arr[i];
                grant_len   = len_arr[i];
                grant_dir   = req_dir[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        owner_next     = owner_reg;
        ptr_next       = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    count_next     = grant_start;
                    remaining_next = grant_len;
                    dir_next       = grant_dir;
                    owner_next     = grant_oh;
                    ptr_next       = grant_ptr_next;
                    state_next     = (grant_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!hold) begin
                    count_next     = dir_reg ? (count_reg + WIDTH'(1))
                                             : (count_reg - WIDTH'(1));
                    remaining_next = remaining_reg - WIDTH'(1);
                    if (remaining_reg == WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
            owner_reg     <= '0;
            ptr_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
            owner_reg     <= owner_next;
            ptr_reg       <= ptr_next;
        end
    end

    // The accept strobe is masked by reset so nothing looks accepted while
    // the block is being cleared.
    assign req_ready = ((state_reg == IDLE) && !reset) ? grant_oh : '0;
    assign count     = count_reg;
    assign owner     = owner_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE) ? owner_reg : '0;

endmodule

// File: tb/tb_count_job_arbiter.sv
// Directed self-checking bench for count_job_arbiter (NREQ=2, WIDTH=4).
module tb_count_job_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*WIDTH-1:0] req_start;
    logic [NREQ*WIDTH-1:0] req_len;
    logic                  hold;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       owner;
    logic                  busy;
    logic [NREQ-1:0]       done;

    int errors = 0;
    int checks = 0;

    count_job_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_start (req_start),
        .req_len   (req_len),
        .hold      (hold),
        .req_ready (req_ready),
        .count     (count),
        .owner     (owner),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int i, input logic [3:0] s, input logic [3:0] l, input logic d);
        req_start[i*WIDTH +: WIDTH] = s;
        req_len[i*WIDTH +: WIDTH]   = l;
        req_dir[i]                  = d;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [3:0] exp_s;
        reset     = 1'b1;
        req_valid = 2'b11;
        req_dir   = '0;
        req_start = '0;
        req_len   = '0;
        hold      = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", req_ready, 0);
        req_valid = 2'b00;
        reset = 1'b0;

        // Single job, up, wrap: 14,15,0,1
        set_job(0, 4'd14, 4'd3, 1'b1);
        req_valid = 2'b01;
        #1;
        chk("t1_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        chk("t1_count0", count, 14);
        chk("t1_busy0", busy, 1);
        chk("t1_owner", owner, 2'b01);
        chk("t1_ready_run", req_ready, 0);
        step(); chk("t1_count1", count, 15);
        step(); chk("t1_count2", count, 0); chk("t1_done_early", done, 0);
        step(); chk("t1_count3", count, 1); chk("t1_done", done, 2'b01); chk("t1_busy3", busy, 1);
        step(); chk("t1_done_off", done, 0); chk("t1_busy_off", busy, 0);
        chk("t1_count_hold", count, 1); chk("t1_owner_hold", owner, 2'b01);

        // Down job on requester 1: 0,15,14
        set_job(1, 4'd0, 4'd2, 1'b0);
        req_valid = 2'b10;
        #1;
        chk("t2_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        chk("t2_count0", count, 0);
        step(); chk("t2_count1", count, 15);
        step(); chk("t2_count2", count, 14); chk("t2_done", done, 2'b10);
        step(); chk("t2_busy_off", busy, 0);

        // Zero-length job: straight to DONE
        set_job(1, 4'd7, 4'd0, 1'b0);
        req_valid = 2'b10;
        #1;
        chk("t2z_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        chk("t2z_count", count, 7); chk("t2z_done", done, 2'b10); chk("t2z_busy", busy, 1);
        step(); chk("t2z_busy_off", busy, 0); chk("t2z_done_off", done, 0);

        // Round-robin with both requesters continuously valid
        set_job(0, 4'd3, 4'd1, 1'b1);
        set_job(1, 4'd8, 4'd1, 1'b1);
        req_valid = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_s = (n % 2 == 0) ? 4'd3 : 4'd8;
            chk($sformatf("rr%0d_ready", n), req_ready, exp_g);
            step();
            chk($sformatf("rr%0d_owner", n), owner, exp_g);
            chk($sformatf("rr%0d_ready_run", n), req_ready, 0);
            chk($sformatf("rr%0d_count0", n), count, exp_s);
            step();
            chk($sformatf("rr%0d_count1", n), count, exp_s + 4'd1);
            chk($sformatf("rr%0d_done", n), done, exp_g);
            chk($sformatf("rr%0d_ready_done", n), req_ready, 0);
            step();
            chk($sformatf("rr%0d_done_off", n), done, 0);
        end
        req_valid = 2'b00;

        // Hold: 5,6,6,6,6,7,8,9
        set_job(0, 4'd5, 4'd4, 1'b1);
        req_valid = 2'b01;
        #1;
        chk("h_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        chk("h_count0", count, 5);
        step(); chk("h_count1", count, 6);
        hold = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("h_held%0d", n), count, 6);
            chk($sformatf("h_held_done%0d", n), done, 0);
        end
        hold = 1'b0;
        step(); chk("h_count2", count, 7);
        step(); chk("h_count3", count, 8); chk("h_done_early", done, 0);
        step(); chk("h_count4", count, 9); chk("h_done", done, 2'b01);
        step(); chk("h_busy_off", busy, 0);

        // Payload changes after accept do not affect the running job
        set_job(0, 4'd2, 4'd3, 1'b1);
        req_valid = 2'b01;
        #1;
        chk("p_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        set_job(0, 4'd9, 4'd0, 1'b0);
        chk("p_count0", count, 2);
        step(); chk("p_count1", count, 3);
        step(); chk("p_count2", count, 4);
        step(); chk("p_count3", count, 5); chk("p_done", done, 2'b01);
        step(); chk("p_busy_off", busy, 0);

        // Asynchronous reset mid-run at count=9
        set_job(0, 4'd7, 4'd5, 1'b1);
        req_valid = 2'b01;
        #1;
        chk("r_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        chk("r_count0", count, 7);
        step(); chk("r_count1", count, 8);
        step(); chk("r_count2", count, 9);
        #3;
        reset = 1'b1;
        #2;
        chk("r_count_rst", count, 0);
        chk("r_busy_rst", busy, 0);
        chk("r_owner_rst", owner, 0);
        chk("r_done_rst", done, 0);
        req_valid = 2'b11;
        #1;
        chk("r_ready_rst", req_ready, 0);
        step();
        chk("r_done_held", done, 0);
        chk("r_count_held", count, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("r_first_grant", req_ready, 2'b01);
        step();
        chk("r_owner_after", owner, 2'b01);
        chk("r_done_after", done, 0);
        req_valid = 2'b00;
        repeat (8) step();
        chk("r_idle_end", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
